reorder_trace_dispatcher: RTL and testbench
===========================================

Name: reorder_trace_dispatcher

Overview:
Upstream feeder for the re-order control block. It accepts one request per ID, carrying the ID and a mask of the queues whose completions that ID must wait for. It serialises each request into one trace entry per set mask bit and pushes the ID once, so the downstream block sees a correctly ordered trace with the breakpoint on the final entry. It honours the downstream full flag as backpressure.

Parameters:
NUM_QUEUES, 4, number of status queues; SEL_WIDTH = clog2(NUM_QUEUES)
DEPTH, 64, downstream queue depth; ID_WIDTH = clog2(DEPTH)
BREAKPOINT, 1'b1, value driven on trace_break_o for the last entry of a request

Ports:
clk_i  in  1  clock
rsn_i  in  1  synchronous active-low reset
req_valid_i  in  1  request offered
req_ready_o  out  1  request accepted when high together with req_valid_i
req_id_i  in  ID_WIDTH  ID of request
req_mask_i  in  NUM_QUEUES  queues the ID must wait on
full_i  in  1  downstream full; stalls pushes
trace_id_push_o  out  1  push ID into mapped-ID queue
trace_id_value_o  out  ID_WIDTH  ID value
trace_push_o  out  1  push trace entry
trace_sel_o  out  SEL_WIDTH  queue selector of entry
trace_break_o  out  1  breakpoint flag of entry
trace_update_o  out  1  mark most recently pushed entry as breakpoint (feature only)
busy_o  out  1  request in progress
err_o  out  1  one-cycle pulse: zero-mask request dropped

Behaviour:
- Single clock. Reset is synchronous and active-low on rsn_i, sampled at the rising edge of clk_i.
- Reset values:
  - req_ready_o=1, busy_o=0.
  - All push, break, update and err outputs = 0.
  - trace_id_value_o=0, trace_sel_o=0.
  - State = IDLE; internal remaining-mask and ID registers = 0.
- All outputs are registered. Push outputs are single-cycle pulses.
- State IDLE:
  - req_ready_o=1.
  - On an edge with req_valid_i=1 and mask≠0: latch ID and mask, move to ISSUE, set first flag, req_ready_o→0, busy_o→1.
  - On an edge with req_valid_i=1 and mask=0: request is consumed, err_o pulses 1 for one cycle, state stays IDLE.
- State ISSUE:
  - At each edge where full_i=0: select s = lowest set bit of the remaining mask.
    - trace_push_o=1 next cycle, trace_sel_o=s, clear bit s.
    - If this is the first entry: trace_id_push_o=1 and trace_id_value_o=latched ID in the same cycle.
    - If the remaining mask becomes 0: trace_break_o=BREAKPOINT, return to IDLE, req_ready_o=1, busy_o=0. Otherwise trace_break_o=~BREAKPOINT.
  - At edges where full_i=1: no push, state and remaining mask held.
- Ordering and timing:
  - Entries are issued in ascending queue index.
  - A request with k set bits and no stall takes 1 accept cycle + k issue cycles. The first push is visible the cycle after the first ISSUE edge.
  - Throughput is one request per k+1 cycles; no acceptance during ISSUE.
- Boundary cases:
  - Mask with all NUM_QUEUES bits set: NUM_QUEUES entries, break on selector NUM_QUEUES-1.
  - full_i toggling mid-request: entries resume exactly where stalled; none lost or duplicated.
  - Reset mid-request: partial request discarded, all outputs return to reset values at the next edge.
- trace_update_o is tied 0 without the optional feature.

Optional Feature:
REORDER_DISPATCH_ABORT_EN
- Adds port abort_i (in, 1).
- Abort in ISSUE after at least one entry pushed: at the edge with abort_i=1, trace_update_o pulses 1 for one cycle, no push occurs, state→IDLE, remaining mask cleared.
- Abort in ISSUE before any entry pushed: request dropped silently, state→IDLE.
- Abort in IDLE: no effect.
- Abort coincident with the last entry: the last entry is issued normally (break set), trace_update_o stays 0.
- Without the macro: no abort_i port and trace_update_o is constant 0.

Test Plan:
- Reset: hold rsn_i=0 for 2 cycles -> req_ready_o=1, busy_o=0, all push/err outputs 0.
- id=5, mask=4'b1010, full_i=0 -> two consecutive pushes:
  - first: sel=1, break=0, with trace_id_push_o=1 and id=5;
  - second: sel=3, break=1;
  - req_ready_o=1 the following cycle.
- mask=4'b1111, full_i=1 for 3 cycles after the first push -> pushes sel 0, then stall, then 1, 2, 3; exactly 4 pushes and 1 ID push.
- mask=4'b0000 -> err_o pulses once, no pushes, state stays IDLE.
- Back-to-back id=2 mask=0001 then id=3 mask=0100 -> two ID pushes (2, 3), sels 0 then 2, both with break=1, gap of one accept cycle.
- With REORDER_DISPATCH_ABORT_EN: mask=4'b0111, abort_i after the first push -> one push (sel 0), then trace_update_o=1 for one cycle, then IDLE.

Source files
------------

// File: rtl/reorder_trace_dispatcher_if.sv
// Request/trace bus for reorder_trace_dispatcher.
// Request side: req_valid_i, req_ready_o, req_id_i, req_mask_i.
// Trace side:   full_i, trace_id_push_o, trace_id_value_o, trace_push_o,
//               trace_sel_o, trace_break_o, trace_update_o.
// master = requester / downstream model, slave = dispatcher.
interface reorder_trace_dispatcher_if #(
  parameter int unsigned NUM_QUEUES = 4,
  parameter int unsigned DEPTH      = 64
);
  localparam int unsigned SEL_WIDTH = (NUM_QUEUES > 1) ? $clog2(NUM_QUEUES) : 1;
  localparam int unsigned ID_WIDTH  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic                  req_valid_i;
  logic                  req_ready_o;
  logic [ID_WIDTH-1:0]   req_id_i;
  logic [NUM_QUEUES-1:0] req_mask_i;
  logic                  full_i;
  logic                  trace_id_push_o;
  logic [ID_WIDTH-1:0]   trace_id_value_o;
  logic                  trace_push_o;
  logic [SEL_WIDTH-1:0]  trace_sel_o;
  logic                  trace_break_o;
  logic                  trace_update_o;

  modport master (
    output req_valid_i, req_id_i, req_mask_i, full_i,
    input  req_ready_o, trace_id_push_o, trace_id_value_o, trace_push_o,
           trace_sel_o, trace_break_o, trace_update_o
  );

  modport slave (
    input  req_valid_i, req_id_i, req_mask_i, full_i,
    output req_ready_o, trace_id_push_o, trace_id_value_o, trace_push_o,
           trace_sel_o, trace_break_o, trace_update_o
  );
endinterface

// File: rtl/reorder_trace_dispatcher.sv
// Upstream feeder for the re-order control block. Accepts one request (ID +
// queue mask), then emits one trace entry per set mask bit in ascending queue
// order, pushing the ID alongside the first entry and flagging the final
// entry with BREAKPOINT. Downstream full_i stalls issuing.
// Ports:
//   clk_i, rsn_i  - clock, synchronous active-low reset
//   bus           - request + trace signals (slave modport)
//   busy_o        - request in progress
//   err_o         - one-cycle pulse when a zero-mask request is dropped
//   abort_i       - abort current request (only with REORDER_DISPATCH_ABORT_EN)
// Optional feature macro: REORDER_DISPATCH_ABORT_EN (adds abort_i and drives
// trace_update_o; without it trace_update_o is constant 0).
module reorder_trace_dispatcher #(
  parameter int unsigned NUM_QUEUES = 4,
  parameter int unsigned DEPTH      = 64,
  parameter logic        BREAKPOINT = 1'b1
) (
  input  logic                      clk_i,
  input  logic                      rsn_i,
`ifdef REORDER_DISPATCH_ABORT_EN
  input  logic                      abort_i,
`endif
  reorder_trace_dispatcher_if.slave bus,
  output logic                      busy_o,
  output logic                      err_o
);
  localparam int unsigned SEL_WIDTH = (NUM_QUEUES > 1) ? $clog2(NUM_QUEUES) : 1;
  localparam int unsigned ID_WIDTH  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } state_e;

  state_e                state_q, state_d;
  logic [NUM_QUEUES-1:0] mask_q, mask_d;
  logic [ID_WIDTH-1:0]   id_q, id_d;
  logic                  first_q, first_d;

  logic                  ready_q, ready_d;
  logic                  busy_q, busy_d;
  logic                  err_q, err_d;
  logic                  push_q, push_d;
  logic                  id_push_q, id_push_d;
  logic [ID_WIDTH-1:0]   id_value_q, id_value_d;
  logic [SEL_WIDTH-1:0]  sel_q, sel_d;
  logic                  break_q, break_d;
`ifdef REORDER_DISPATCH_ABORT_EN
  logic                  update_q, update_d;
`endif

  logic [SEL_WIDTH-1:0]  low_sel_c;
  logic [NUM_QUEUES-1:0] mask_clr_c;
  logic                  issue_c;
  logic                  last_c;

  // Lowest set bit of the remaining mask, and the mask with that bit removed.
  always_comb begin
    low_sel_c = '0;
    for (int i = int'(NUM_QUEUES) - 1; i >= 0; i--) begin
      if (mask_q[i]) low_sel_c = SEL_WIDTH'(i);
    end
    mask_clr_c = mask_q & ~(NUM_QUEUES'(1) << low_sel_c);
    issue_c    = (state_q == ISSUE) && !bus.full_i;
    last_c     = issue_c && (mask_clr_c == '0);
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d    = state_q;
    mask_d     = mask_q;
    id_d       = id_q;
    first_d    = first_q;
    err_d      = 1'b0;
    push_d     = 1'b0;
    id_push_d  = 1'b0;
    id_value_d = id_value_q;
    sel_d      = sel_q;
    break_d    = 1'b0;
`ifdef REORDER_DISPATCH_ABORT_EN
    update_d   = 1'b0;
`endif

    case (state_q)
      IDLE: begin
        if (bus.req_valid_i) begin
          if (|bus.req_mask_i) begin
            state_d = ISSUE;
            mask_d  = bus.req_mask_i;
            id_d    = bus.req_id_i;
            first_d = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ISSUE: begin
`ifdef REORDER_DISPATCH_ABORT_EN
        // A final entry issuing on this edge wins over abort.
        if (abort_i && !last_c) begin
          state_d  = IDLE;
          mask_d   = '0;
          first_d  = 1'b0;
          update_d = !first_q;
        end else
`endif
        if (issue_c) begin
          push_d  = 1'b1;
          sel_d   = low_sel_c;
          mask_d  = mask_clr_c;
          first_d = 1'b0;
          if (first_q) begin
            id_push_d  = 1'b1;
            id_value_d = id_q;
          end
          if (last_c) begin
            break_d = BREAKPOINT;
            state_d = IDLE;
          end else begin
            break_d = ~BREAKPOINT;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    ready_d = (state_d == IDLE);
    busy_d  = (state_d == ISSUE);
  end

  // State and output registers.
  always_ff @(posedge clk_i) begin
    if (!rsn_i) begin
      state_q    <= IDLE;
      mask_q     <= '0;
      id_q       <= '0;
      first_q    <= 1'b0;
      ready_q    <= 1'b1;
      busy_q     <= 1'b0;
      err_q      <= 1'b0;
      push_q     <= 1'b0;
      id_push_q  <= 1'b0;
      id_value_q <= '0;
      sel_q      <= '0;
      break_q    <= 1'b0;
`ifdef REORDER_DISPATCH_ABORT_EN
      update_q   <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      mask_q     <= mask_d;
      id_q       <= id_d;
      first_q    <= first_d;
      ready_q    <= ready_d;
      busy_q     <= busy_d;
      err_q      <= err_d;
      push_q     <= push_d;
      id_push_q  <= id_push_d;
      id_value_q <= id_value_d;
      sel_q      <= sel_d;
      break_q    <= break_d;
`ifdef REORDER_DISPATCH_ABORT_EN
      update_q   <= update_d;
`endif
    end
  end

  assign bus.req_ready_o      = ready_q;
  assign bus.trace_push_o     = push_q;
  assign bus.trace_id_push_o  = id_push_q;
  assign bus.trace_id_value_o = id_value_q;
  assign bus.trace_sel_o      = sel_q;
  assign bus.trace_break_o    = break_q;
`ifdef REORDER_DISPATCH_ABORT_EN
  assign bus.trace_update_o   = update_q;
`else
  assign bus.trace_update_o   = 1'b0;
`endif
  assign busy_o = busy_q;
  assign err_o  = err_q;

endmodule

// File: tb/tb_reorder_trace_dispatcher.sv
// Directed self-checking bench for reorder_trace_dispatcher.
module tb_reorder_trace_dispatcher;
  localparam int unsigned NQ    = 4;
  localparam int unsigned DEPTH = 64;

  // Control snapshot: {push, id_push, break, ready, busy, err, update}
  localparam logic [6:0] C_IDLE  = 7'b000_1000;
  localparam logic [6:0] C_BUSY  = 7'b000_0100;
  localparam logic [6:0] C_ERR   = 7'b000_1010;
  localparam logic [6:0] C_FIRST = 7'b110_0100;
  localparam logic [6:0] C_MID   = 7'b100_0100;
  localparam logic [6:0] C_LAST  = 7'b101_1000;
  localparam logic [6:0] C_ONLY  = 7'b111_1000;
`ifdef REORDER_DISPATCH_ABORT_EN
  localparam logic [6:0] C_UPD   = 7'b000_1001;
  logic abort;
`endif

  logic clk_i = 1'b0;
  logic rsn_i = 1'b0;
  logic busy, err;
  logic [6:0] ctl;
  int n_tests = 0;
  int n_fail  = 0;

  reorder_trace_dispatcher_if #(.NUM_QUEUES(NQ), .DEPTH(DEPTH)) bus ();

  reorder_trace_dispatcher #(.NUM_QUEUES(NQ), .DEPTH(DEPTH), .BREAKPOINT(1'b1)) dut (
    .clk_i  (clk_i),
    .rsn_i  (rsn_i),
`ifdef REORDER_DISPATCH_ABORT_EN
    .abort_i(abort),
`endif
    .bus    (bus),
    .busy_o (busy),
    .err_o  (err)
  );

  always #5 clk_i = ~clk_i;

  assign ctl = {bus.trace_push_o, bus.trace_id_push_o, bus.trace_break_o,
                bus.req_ready_o, busy, err, bus.trace_update_o};

  task automatic tick;
    @(posedge clk_i);
    #1;
  endtask

  task automatic test_reset;
    rsn_i = 1'b0;
    tick();
    tick();
    n_tests++;
    if (ctl !== C_IDLE) begin n_fail++; $display("FAIL reset_ctl got=%b exp=%b", ctl, C_IDLE); end
    n_tests++;
    if (bus.trace_sel_o !== 2'd0 || bus.trace_id_value_o !== 6'd0) begin
      n_fail++; $display("FAIL reset_sel_id got sel=%0d id=%0d exp 0/0", bus.trace_sel_o, bus.trace_id_value_o);
    end
    rsn_i = 1'b1;
    tick();
    n_tests++;
    if (ctl !== C_IDLE) begin n_fail++; $display("FAIL reset_release got=%b exp=%b", ctl, C_IDLE); end
  endtask

  task automatic test_basic;
    bus.req_valid_i = 1'b1; bus.req_id_i = 6'd5; bus.req_mask_i = 4'b1010;
    tick();
    bus.req_valid_i = 1'b0;
    n_tests++;
    if (ctl !== C_BUSY) begin n_fail++; $display("FAIL basic_accept got=%b exp=%b", ctl, C_BUSY); end
    tick();
    n_tests++;
    if (ctl !== C_FIRST || bus.trace_sel_o !== 2'd1 || bus.trace_id_value_o !== 6'd5) begin
      n_fail++; $display("FAIL basic_first got ctl=%b sel=%0d id=%0d exp ctl=%b sel=1 id=5",
                         ctl, bus.trace_sel_o, bus.trace_id_value_o, C_FIRST);
    end
    tick();
    n_tests++;
    if (ctl !== C_LAST || bus.trace_sel_o !== 2'd3) begin
      n_fail++; $display("FAIL basic_last got ctl=%b sel=%0d exp ctl=%b sel=3", ctl, bus.trace_sel_o, C_LAST);
    end
    tick();
    n_tests++;
    if (ctl !== C_IDLE) begin n_fail++; $display("FAIL basic_idle got=%b exp=%b", ctl, C_IDLE); end
  endtask

  task automatic test_stall;
    logic [6:0] exp_ctl [7];
    logic [1:0] exp_sel [7];
    int pushes = 0;
    int id_pushes = 0;
    exp_ctl = '{C_FIRST, C_BUSY, C_BUSY, C_BUSY, C_MID, C_MID, C_LAST};
    exp_sel = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd1, 2'd2, 2'd3};
    bus.req_valid_i = 1'b1; bus.req_id_i = 6'd7; bus.req_mask_i = 4'b1111;
    tick();
    bus.req_valid_i = 1'b0;
    for (int i = 0; i < 7; i++) begin
      tick();
      if (bus.trace_push_o === 1'b1) pushes++;
      if (bus.trace_id_push_o === 1'b1) id_pushes++;
      n_tests++;
      if (ctl !== exp_ctl[i] || (exp_ctl[i][6] && bus.trace_sel_o !== exp_sel[i])) begin
        n_fail++; $display("FAIL stall_cycle%0d got ctl=%b sel=%0d exp ctl=%b sel=%0d",
                           i, ctl, bus.trace_sel_o, exp_ctl[i], exp_sel[i]);
      end
      bus.full_i = (i < 3);
    end
    n_tests++;
    if (pushes != 4 || id_pushes != 1) begin
      n_fail++; $display("FAIL stall_counts got push=%0d idpush=%0d exp 4/1", pushes, id_pushes);
    end
  endtask

  task automatic test_zero_mask;
    bus.req_valid_i = 1'b1; bus.req_id_i = 6'd9; bus.req_mask_i = 4'b0000;
    tick();
    bus.req_valid_i = 1'b0;
    n_tests++;
    if (ctl !== C_ERR) begin n_fail++; $display("FAIL zero_mask_err got=%b exp=%b", ctl, C_ERR); end
    tick();
    n_tests++;
    if (ctl !== C_IDLE) begin n_fail++; $display("FAIL zero_mask_after got=%b exp=%b", ctl, C_IDLE); end
  endtask

  task automatic test_back_to_back;
    bus.req_valid_i = 1'b1; bus.req_id_i = 6'd2; bus.req_mask_i = 4'b0001;
    tick();
    bus.req_id_i = 6'd3; bus.req_mask_i = 4'b0100;
    n_tests++;
    if (ctl !== C_BUSY) begin n_fail++; $display("FAIL b2b_accept1 got=%b exp=%b", ctl, C_BUSY); end
    tick();
    n_tests++;
    if (ctl !== C_ONLY || bus.trace_sel_o !== 2'd0 || bus.trace_id_value_o !== 6'd2) begin
      n_fail++; $display("FAIL b2b_entry1 got ctl=%b sel=%0d id=%0d exp ctl=%b sel=0 id=2",
                         ctl, bus.trace_sel_o, bus.trace_id_value_o, C_ONLY);
    end
    tick();
    bus.req_valid_i = 1'b0;
    n_tests++;
    if (ctl !== C_BUSY) begin n_fail++; $display("FAIL b2b_accept2 got=%b exp=%b", ctl, C_BUSY); end
    tick();
    n_tests++;
    if (ctl !== C_ONLY || bus.trace_sel_o !== 2'd2 || bus.trace_id_value_o !== 6'd3) begin
      n_fail++; $display("FAIL b2b_entry2 got ctl=%b sel=%0d id=%0d exp ctl=%b sel=2 id=3",
                         ctl, bus.trace_sel_o, bus.trace_id_value_o, C_ONLY);
    end
    tick();
  endtask

  task automatic test_reset_mid;
    bus.req_valid_i = 1'b1; bus.req_id_i = 6'd11; bus.req_mask_i = 4'b1110;
    tick();
    bus.req_valid_i = 1'b0;
    tick();
    n_tests++;
    if (ctl !== C_FIRST || bus.trace_sel_o !== 2'd1) begin
      n_fail++; $display("FAIL rstmid_first got ctl=%b sel=%0d exp ctl=%b sel=1", ctl, bus.trace_sel_o, C_FIRST);
    end
    rsn_i = 1'b0;
    tick();
    rsn_i = 1'b1;
    n_tests++;
    if (ctl !== C_IDLE || bus.trace_sel_o !== 2'd0 || bus.trace_id_value_o !== 6'd0) begin
      n_fail++; $display("FAIL rstmid_reset got ctl=%b sel=%0d id=%0d exp ctl=%b 0/0",
                         ctl, bus.trace_sel_o, bus.trace_id_value_o, C_IDLE);
    end
    tick();
    n_tests++;
    if (ctl !== C_IDLE) begin n_fail++; $display("FAIL rstmid_discard got=%b exp=%b", ctl, C_IDLE); end
  endtask

`ifdef REORDER_DISPATCH_ABORT_EN
  task automatic test_abort;
    bus.req_valid_i = 1'b1; bus.req_id_i = 6'd6; bus.req_mask_i = 4'b0111;
    tick();
    bus.req_valid_i = 1'b0;
    tick();
    n_tests++;
    if (ctl !== C_FIRST || bus.trace_sel_o !== 2'd0) begin
      n_fail++; $display("FAIL abort_first got ctl=%b sel=%0d exp ctl=%b sel=0", ctl, bus.trace_sel_o, C_FIRST);
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    n_tests++;
    if (ctl !== C_UPD) begin n_fail++; $display("FAIL abort_update got=%b exp=%b", ctl, C_UPD); end
    tick();
    n_tests++;
    if (ctl !== C_IDLE) begin n_fail++; $display("FAIL abort_idle got=%b exp=%b", ctl, C_IDLE); end
    // Abort in IDLE does nothing.
    abort = 1'b1;
    tick();
    n_tests++;
    if (ctl !== C_IDLE) begin n_fail++; $display("FAIL abort_in_idle got=%b exp=%b", ctl, C_IDLE); end
    // Abort coincident with the last entry: entry issued normally.
    bus.req_valid_i = 1'b1; bus.req_id_i = 6'd4; bus.req_mask_i = 4'b0001;
    abort = 1'b0;
    tick();
    bus.req_valid_i = 1'b0;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    n_tests++;
    if (ctl !== C_ONLY || bus.trace_id_value_o !== 6'd4) begin
      n_fail++; $display("FAIL abort_last got ctl=%b id=%0d exp ctl=%b id=4", ctl, bus.trace_id_value_o, C_ONLY);
    end
    tick();
  endtask
`endif

  initial begin
    bus.req_valid_i = 1'b0;
    bus.req_id_i    = '0;
    bus.req_mask_i  = '0;
    bus.full_i      = 1'b0;
`ifdef REORDER_DISPATCH_ABORT_EN
    abort = 1'b0;
`endif
    test_reset();
    test_basic();
    test_stall();
    test_zero_mask();
    test_back_to_back();
    test_reset_mid();
`ifdef REORDER_DISPATCH_ABORT_EN
    test_abort();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
